// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the combinational instruction memory address,
// and holds the fetched word in an IF/ID register handed to decode by valid/ready.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_enable,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] address,
    input  logic [31:0] instruction,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] fetch_count
);

    logic [31:0] pc;
    logic        advance;
    logic        handoff;

    // The output register may be refilled when empty or when decode drains it this cycle.
    assign advance     = fetch_enable && (!if_valid || if_ready);
    assign handoff     = if_valid && if_ready;
    assign address     = pc;
    assign if_pc_plus4 = if_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            if_valid       <= 1'b0;
            if_instruction <= '0;
            if_pc          <= '0;
            fetch_count    <= '0;
        end else begin
            if (handoff)
                fetch_count <= fetch_count + 32'd1;

            // A redirect flushes the output register and discards the word at address.
            if (branch_taken) begin
                pc       <= {branch_target[31:2], 2'b00};
                if_valid <= 1'b0;
            end else if (advance) begin
                if_instruction <= instruction;
                if_pc          <= pc;
                if_valid       <= 1'b1;
                pc             <= pc + 32'd4;
            end else if (handoff) begin
                // Fetch disabled: let the last accepted instruction drain.
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a combinational memory model answers the
// fetch address, and each scenario task checks the IF/ID outputs cycle by cycle.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_enable;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] address;
    logic [31:0] instruction;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] fetch_count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign instruction = mem_word(address);

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .fetch_enable(fetch_enable),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .address(address), .instruction(instruction),
        .if_instruction(if_instruction), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
        .if_valid(if_valid), .if_ready(if_ready), .fetch_count(fetch_count)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; fetch_enable = 1'b1; if_ready = 1'b1;
        branch_taken = 1'b0; branch_target = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; fetch_enable = 1'b0; if_ready = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        tick(); tick();
        n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0h want 0", if_valid); end
        n_cmp++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", if_pc); end
        n_cmp++; if (if_instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", if_instruction); end
        n_cmp++; if (fetch_count !== 32'h0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fetch_count); end
        n_cmp++; if (address !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", address); end
        n_cmp++; if (if_pc_plus4 !== 32'd4) begin n_fail++; $display("FAIL reset_plus4 got %h want 4", if_pc_plus4); end
    endtask

    task automatic test_free_run();
        do_reset();
        for (int i = 0; i < 25; i++) begin
            n_cmp++; if (address !== 32'(4*i)) begin n_fail++; $display("FAIL run_addr[%0d] got %h want %h", i, address, 32'(4*i)); end
            tick();
            n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'(4*i)) begin n_fail++; $display("FAIL run_pc[%0d] got v=%0b pc=%h want v=1 pc=%h", i, if_valid, if_pc, 32'(4*i)); end
            n_cmp++; if (if_instruction !== mem_word(32'(4*i))) begin n_fail++; $display("FAIL run_instr[%0d] got %h want %h", i, if_instruction, mem_word(32'(4*i))); end
        end
        // Disable fetch: the word at 96 is handed off and the register drains.
        fetch_enable = 1'b0;
        tick();
        n_cmp++; if (fetch_count !== 32'd25) begin n_fail++; $display("FAIL run_count got %0d want 25", fetch_count); end
        n_cmp++; if (if_valid !== 1'b0 || address !== 32'd100) begin n_fail++; $display("FAIL drain got v=%0b addr=%h want v=0 addr=64", if_valid, address); end
        tick();
        n_cmp++; if (address !== 32'd100 || fetch_count !== 32'd25) begin n_fail++; $display("FAIL frozen got addr=%h cnt=%0d want 64/25", address, fetch_count); end
        fetch_enable = 1'b1;
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd100) begin n_fail++; $display("FAIL resume got v=%0b pc=%h want v=1 pc=64", if_valid, if_pc); end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        do_reset();
        tick(); tick(); tick();
        n_cmp++; if (if_pc !== 32'd8 || address !== 32'd12) begin n_fail++; $display("FAIL stall_setup got pc=%h addr=%h want 8/c", if_pc, address); end
        held = mem_word(32'd8);
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (if_pc !== 32'd8 || if_instruction !== held || if_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d] got pc=%h instr=%h v=%0b want 8/%h/1", i, if_pc, if_instruction, if_valid, held); end
            n_cmp++; if (address !== 32'd12 || fetch_count !== 32'd2) begin n_fail++; $display("FAIL stall_addr[%0d] got addr=%h cnt=%0d want c/2", i, address, fetch_count); end
        end
        if_ready = 1'b1;
        tick();
        n_cmp++; if (if_pc !== 32'd12 || fetch_count !== 32'd3) begin n_fail++; $display("FAIL stall_release got pc=%h cnt=%0d want c/3", if_pc, fetch_count); end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        n_cmp++; if (address !== 32'd20) begin n_fail++; $display("FAIL redir_setup got addr=%h want 14", address); end
        branch_taken = 1'b1; branch_target = 32'd42;
        tick();
        branch_taken = 1'b0;
        n_cmp++; if (address !== 32'd40 || if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_bubble got addr=%h v=%0b want 28/0", address, if_valid); end
        n_cmp++; if (fetch_count !== 32'd5) begin n_fail++; $display("FAIL redir_count got %0d want 5", fetch_count); end
        tick();
        n_cmp++; if (if_pc !== 32'd40 || if_valid !== 1'b1 || if_instruction !== mem_word(32'd40)) begin n_fail++; $display("FAIL redir_target got pc=%h v=%0b instr=%h want 28/1/%h", if_pc, if_valid, if_instruction, mem_word(32'd40)); end

        // Redirect while stalled: the held instruction is dropped uncounted.
        if_ready = 1'b0;
        tick();
        branch_taken = 1'b1; branch_target = 32'd64;
        tick();
        branch_taken = 1'b0;
        n_cmp++; if (if_valid !== 1'b0 || fetch_count !== 32'd5 || address !== 32'd64) begin n_fail++; $display("FAIL redir_stall got v=%0b cnt=%0d addr=%h want 0/5/40", if_valid, fetch_count, address); end
        if_ready = 1'b1;
        tick();
        n_cmp++; if (if_pc !== 32'd64 || if_valid !== 1'b1 || fetch_count !== 32'd5) begin n_fail++; $display("FAIL redir_stall_next got pc=%h v=%0b cnt=%0d want 40/1/5", if_pc, if_valid, fetch_count); end
    endtask

    task automatic test_back_to_back();
        branch_taken = 1'b1; branch_target = 32'd200;
        tick();
        branch_target = 32'd301;
        tick();
        branch_taken = 1'b0;
        n_cmp++; if (address !== 32'd300 || if_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble got addr=%h v=%0b want 12c/0", address, if_valid); end
        tick();
        n_cmp++; if (if_pc !== 32'd300 || if_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_target got pc=%h v=%0b want 12c/1", if_pc, if_valid); end
    endtask

    task automatic test_wrap();
        if_ready = 1'b1;
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
        tick();
        branch_taken = 1'b0;
        n_cmp++; if (address !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0 got %h want fffffffc", address); end
        tick();
        n_cmp++; if (address !== 32'h0 || if_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr1 got addr=%h pc=%h want 0/fffffffc", address, if_pc); end
        n_cmp++; if (if_pc_plus4 !== 32'h0 || if_instruction !== mem_word(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wrap_plus4 got %h instr=%h want 0/%h", if_pc_plus4, if_instruction, mem_word(32'hFFFF_FFFC)); end
        tick();
        n_cmp++; if (if_pc !== 32'h0 || address !== 32'd4) begin n_fail++; $display("FAIL wrap_next got pc=%h addr=%h want 0/4", if_pc, address); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        n_cmp++; if (fetch_count !== 32'd7 || if_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_setup got cnt=%0d v=%0b want 7/1", fetch_count, if_valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (if_valid !== 1'b0 || fetch_count !== 32'd0 || address !== 32'h0) begin n_fail++; $display("FAIL rmid_reset got v=%0b cnt=%0d addr=%h want 0/0/0", if_valid, fetch_count, address); end
        tick();
        n_cmp++; if (if_pc !== 32'h0 || if_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_restart got pc=%h v=%0b want 0/1", if_pc, if_valid); end
        tick();
        n_cmp++; if (if_pc !== 32'd4 || fetch_count !== 32'd1) begin n_fail++; $display("FAIL rmid_next got pc=%h cnt=%0d want 4/1", if_pc, fetch_count); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage feeding the pipeline from the combinational `instruction_memory`. Holds the program counter and drives the memory's `address`. Captures the returned `instruction` into an IF/ID output register with a valid/ready handshake toward decode. Supports stalls, branch/jump redirects with flush, and wrap-around of the 32-bit byte address.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `fetch_enable`  input  1  when low, no new instruction is fetched.
- `branch_taken`  input  1  redirect request, valid for one cycle.
- `branch_target`  input  32  redirect byte address; bits [1:0] are forced to 0.
- `address`  output  32  byte address to `instruction_memory`; equals current PC combinationally.
- `instruction`  input  32  word returned by `instruction_memory` for `address`, same cycle.
- `if_instruction`  output  32  registered instruction handed to decode.
- `if_pc`  output  32  PC of `if_instruction`.
- `if_pc_plus4`  output  32  `if_pc + 4`, modulo 2^32.
- `if_valid`  output  1  `if_instruction`/`if_pc` hold a live instruction.
- `if_ready`  input  1  decode accepts the output this cycle.
- `fetch_count`  output  32  number of completed handoffs (`if_valid && if_ready`) since reset, wraps.

## Operation
- State:
  - `pc` (32b)
  - output register {`if_instruction`, `if_pc`, `if_valid`}
  - `fetch_count`
- `advance = fetch_enable && (!if_valid || if_ready)`.
- Priority per edge, highest first: reset > redirect > advance > hold.
- Reset:
  - `pc` = `RESET_PC`; `if_valid` = 0; `if_instruction` = 0; `if_pc` = 0; `fetch_count` = 0.
  - At reset, `address` = `RESET_PC` and `if_pc_plus4` = 4.
- Redirect (`branch_taken` = 1):
  - `pc` = {`branch_target`[31:2], 2'b00}; `if_valid` = 0 (flush), regardless of `if_ready`, `fetch_enable` or stall.
  - The instruction currently at `address` is discarded.
  - `fetch_count` still increments if `if_valid && if_ready` in that cycle.
- Advance (no redirect, `advance` = 1):
  - `if_instruction` = `instruction`; `if_pc` = `pc`; `if_valid` = 1; `pc` = `pc + 4`.
  - Arithmetic is 32-bit unsigned: `pc` 32'hFFFF_FFFC advances to 32'h0000_0000.
- Hold (no redirect, `advance` = 0):
  - `pc` and the output register are unchanged, except: if `if_valid && if_ready && !fetch_enable`, then `if_valid` = 0.
- `fetch_count` increments by 1 on every edge (outside reset) where `if_valid && if_ready`.
- `if_ready` while `if_valid` = 0 has no effect.
- Outputs are stable while `if_valid && !if_ready` (stall): no field of the output register changes unless redirect or reset.

## Timing
- `address` is combinational from `pc`, with zero-cycle memory access. The instruction at PC p appears on `if_instruction` the cycle after `address` = p, given `advance`.
- Steady state (`if_ready` = 1, `fetch_enable` = 1): one instruction per cycle. After reset is released at edge E0, `if_valid` rises at edge E1 with `if_pc` = `RESET_PC`.
- Redirect at cycle N (sampled at edge N):
  - cycle N+1: `address` = target, `if_valid` = 0 (one bubble).
  - cycle N+2: `if_pc` = target, `if_valid` = 1.
- Back-to-back redirects: the last one wins. Each flushes.
- Redirect coincident with stall: the flush wins. The stalled instruction is dropped and is not counted unless `if_ready` was 1.
- Reset mid-stall or mid-redirect: reset wins completely on that edge.
- `fetch_enable` deasserted: `pc` freezes and the output drains once accepted. Re-assertion resumes at the frozen `pc` with no skip or duplicate.

## Test plan
- Reset then free-run with `if_ready` = 1, memory preloaded: `address` steps 0,4,8,…,96. `if_pc` lags `address` by one cycle. `if_instruction` matches memory word `address`/4. `fetch_count` = 25 after 25 handoffs.
- Stall: hold `if_ready` = 0 for 3 cycles while `if_pc` = 8. Required:
  - `if_pc` stays 8 and `if_instruction` is constant.
  - `address` stays 12.
  - `fetch_count` is unchanged.
  - On release, the next `if_pc` is 12; no skip, no duplicate.
- Redirect: `branch_taken` = 1, `branch_target` = 32'd42 at a cycle where `address` = 20. Required:
  - next cycle: `address` = 40, `if_valid` = 0.
  - following cycle: `if_pc` = 40, `if_valid` = 1.
  - The word at address 20 is never presented.
- Redirect during stall: `if_valid` = 1, `if_ready` = 0, `branch_taken` = 1 to 32'd64. Required: the stalled instruction is flushed, `fetch_count` is unchanged, and the next presented `if_pc` = 64.
- Wrap: redirect to 32'hFFFF_FFFC with `if_ready` = 1. Required: the next `address` values are FFFF_FFFC then 0000_0000, and `if_pc_plus4` = 0 when `if_pc` = FFFF_FFFC.
- Reset mid-run: assert `reset` for one cycle while `if_valid` = 1 and `fetch_count` = 7. Required:
  - on the next cycle, `if_valid` = 0, `fetch_count` = 0, `address` = `RESET_PC`.
  - fetching restarts at `RESET_PC`.
